// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared definitions for the PULPino boot/run sequencer.
//   - state_e      : FSM state encodings (3-bit, visible on state_o)
//   - BOOT_CNT_MAX : saturation value of the boot counter
package boot_seq_pkg;

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLoad = 3'd1,
    StRun      = 3'd2,
    StHalt     = 3'd3
  } state_e;

  localparam logic [7:0] BOOT_CNT_MAX = 8'd255;

endpackage

// File: rtl/boot_sync.sv
// boot_sync: single-bit multi-flop synchronizer for an asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; all stages load RESET_VAL
//   i_d   - asynchronous input
//   o_q   - synchronized output (last stage)
module boot_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: boot/run sequencer between board controls and the PULPino SoC.
// Generates the SoC reset and fetch enable, holds the core while the SPI boot
// loader is active, and supports start, halt and warm restart.
// Optional watchdog enabled by defining BOOT_SEQ_WATCHDOG_EN.
// Ports:
//   clk            - single clock
//   rst_n          - asynchronous active-low reset
//   fetch_req_i    - async; synchronized rising edge requests start/restart
//   halt_req_i     - async level; forces HALT while in RUN
//   spi_cs_i       - async SPI-slave chip select, active low
//   wdt_kick_i     - synchronous watchdog kick pulse
//   soc_rst_no     - SoC reset, active low
//   fetch_enable_o - SoC fetch enable
//   state_o        - current FSM state
//   boot_count_o   - entries into RUN, saturating
//   wdt_fired_o    - sticky watchdog-expiry flag
module boot_seq_ctrl
  import boot_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned IDLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDT_CYCLES  = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_req_i,
  input  logic       halt_req_i,
  input  logic       spi_cs_i,
  input  logic       wdt_kick_i,
  output logic       soc_rst_no,
  output logic       fetch_enable_o,
  output logic [2:0] state_o,
  output logic [7:0] boot_count_o,
  output logic       wdt_fired_o
);

  localparam logic [CNT_W-1:0] RstLast  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);

  logic w_fetch_s, w_halt_s, w_cs_s, w_fetch_edge, w_wdt_expire;
  logic r_fetch_prev;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_spi_seen, w_spi_seen_d;
  logic [7:0]       r_boot_cnt;
  logic             r_soc_rst_n, r_fetch_en, r_wdt_fired;

  boot_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_fetch (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (fetch_req_i),
    .o_q   (w_fetch_s)
  );

  boot_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_halt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (halt_req_i),
    .o_q   (w_halt_s)
  );

  // Chip select idles high, so its synchronizer resets to 1.
  boot_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (spi_cs_i),
    .o_q   (w_cs_s)
  );

  assign w_fetch_edge = w_fetch_s & ~r_fetch_prev;

`ifdef BOOT_SEQ_WATCHDOG_EN
  localparam int unsigned  WdtW    = $clog2(WDT_CYCLES + 1);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

  logic [WdtW-1:0] r_wdt_cnt;

  assign w_wdt_expire = (r_wdt_cnt == WdtLast);

  // Runs only while staying in RUN; a kick or any exit clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt   <= '0;
      r_wdt_fired <= 1'b0;
    end else begin
      if (r_state == StRun && w_state_d == StRun && !wdt_kick_i) begin
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end else begin
        r_wdt_cnt <= '0;
      end
      if (r_state == StRun && !w_halt_s && w_wdt_expire) begin
        r_wdt_fired <= 1'b1;
      end
    end
  end
`else
  logic w_unused_wdt;

  assign w_unused_wdt = wdt_kick_i ^ (WDT_CYCLES == 0);
  assign w_wdt_expire = 1'b0;
  assign r_wdt_fired  = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_spi_seen_d = r_spi_seen;
    case (r_state)
      StReset: begin
        if (r_cnt == RstLast) begin
          w_state_d    = StWaitLoad;
          w_cnt_d      = '0;
          w_spi_seen_d = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StWaitLoad: begin
        if (!w_cs_s) begin
          w_spi_seen_d = 1'b1;
          w_cnt_d      = '0;
        end else if (r_spi_seen) begin
          if (r_cnt == IdleLast) begin
            w_state_d = StRun;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        if (w_fetch_edge) begin
          w_state_d = StRun;
        end
        if (w_state_d == StRun) begin
          w_cnt_d = '0;
        end
      end
      StRun: begin
        w_cnt_d = '0;
        // Halt wins over a simultaneous restart edge or watchdog expiry.
        if (w_halt_s) begin
          w_state_d = StHalt;
        end else if (w_fetch_edge || w_wdt_expire) begin
          w_state_d = StReset;
        end
      end
      StHalt: begin
        w_cnt_d = '0;
        if (w_fetch_edge) begin
          w_state_d = StReset;
        end
      end
      default: begin
        w_state_d = StReset;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StReset;
      r_cnt        <= '0;
      r_spi_seen   <= 1'b0;
      r_fetch_prev <= 1'b0;
      r_boot_cnt   <= '0;
      r_soc_rst_n  <= 1'b0;
      r_fetch_en   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_spi_seen   <= w_spi_seen_d;
      r_fetch_prev <= w_fetch_s;
      if (r_state != StRun && w_state_d == StRun && r_boot_cnt != BOOT_CNT_MAX) begin
        r_boot_cnt <= r_boot_cnt + 1'b1;
      end
      // Decoded from the current state, so these lag a transition by one cycle.
      r_soc_rst_n <= (r_state != StReset);
      r_fetch_en  <= (r_state == StRun);
    end
  end

  assign soc_rst_no     = r_soc_rst_n;
  assign fetch_enable_o = r_fetch_en;
  assign state_o        = r_state;
  assign boot_count_o   = r_boot_cnt;
  assign wdt_fired_o    = r_wdt_fired;

endmodule
